// File: rtl/calc_sequencer.sv
// Sequenced 4-bit calculator: add/sub in one cycle, shift-add multiply and restoring divide over four.
// Optional macro CALC_DIV_EN enables the divider; without it op=11 reports error code 8'hE2.
module calc_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       neg,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  work_q, work_d;
    logic [7:0]  result_q, result_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;

    logic [7:0]  mul_step;
`ifdef CALC_DIV_EN
    logic [1:0]  div_idx;
    logic [4:0]  div_trial;
    logic        div_fits;
    logic [3:0]  div_rem;
    logic [3:0]  div_quo;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;

        // work_q holds the partial product, or {quotient, remainder} while dividing
        mul_step = work_q + (b_q[cnt_q] ? ({4'h0, a_q} << cnt_q) : 8'h00);
`ifdef CALC_DIV_EN
        div_idx   = 2'd3 - cnt_q;
        div_trial = {work_q[3:0], a_q[div_idx]};
        div_fits  = (div_trial >= {1'b0, b_q});
        div_rem   = div_fits ? (div_trial[3:0] - b_q) : div_trial[3:0];
        div_quo   = {work_q[6:4], div_fits};
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op_t'(op);
                    cnt_d   = '0;
                    work_d  = '0;
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_ADD: begin
                        result_d = {4'h0, a_q} + {4'h0, b_q};
                        neg_d    = 1'b0;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                    OP_SUB: begin
                        result_d = (a_q >= b_q) ? {4'h0, a_q - b_q} : {4'h0, b_q - a_q};
                        neg_d    = (a_q < b_q);
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                    OP_MUL: begin
                        work_d = mul_step;
                        if (cnt_q == 2'd3) begin
                            result_d = mul_step;
                            neg_d    = 1'b0;
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                    OP_DIV: begin
`ifdef CALC_DIV_EN
                        work_d = {div_quo, div_rem};
                        if (cnt_q == 2'd3) begin
                            result_d = (b_q == 4'h0) ? 8'hE1 : {div_quo, div_rem};
                            neg_d    = 1'b0;
                            err_d    = (b_q == 4'h0);
                            state_d  = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
`else
                        result_d = 8'hE2;
                        neg_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
`endif
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule
